// File: rtl/l1_access_arbiter_if.sv
// Requester, L1-lookup and status signals of the L1 access arbiter.
// Field widths are derived from the cache geometry the same way as in the arbiter.
interface l1_access_arbiter_if #(
  parameter int BLOCK_SIZE_BYTE = 16,
  parameter int CACHE_SIZE_BYTE = 32768,
  parameter int WAY             = 4
);
  localparam int OFF_W = $clog2(BLOCK_SIZE_BYTE);
  localparam int SET_W = $clog2(CACHE_SIZE_BYTE / (BLOCK_SIZE_BYTE * WAY));
  localparam int TAG_W = 32 - SET_W - OFF_W;

  logic              req0_valid;
  logic              req1_valid;
  logic [31:0]       req0_addr;
  logic [31:0]       req1_addr;
  logic              req0_ready;
  logic              req1_ready;
  logic              find_start;
  logic [TAG_W-1:0]  tag;
  logic [SET_W-1:0]  index;
  logic [OFF_W-1:0]  block_offset;
  logic              found_in_cache;
  logic              updated;
  logic              resp_valid;
  logic              resp_id;
  logic              resp_hit;
  logic              busy;
  logic              timeout_err;
  logic [19:0]       access_count;
  logic [19:0]       miss_count;

  modport slave (
    input  req0_valid, req1_valid, req0_addr, req1_addr, found_in_cache, updated,
    output req0_ready, req1_ready, find_start, tag, index, block_offset,
           resp_valid, resp_id, resp_hit, busy, timeout_err, access_count, miss_count
  );

  modport master (
    output req0_valid, req1_valid, req0_addr, req1_addr, found_in_cache, updated,
    input  req0_ready, req1_ready, find_start, tag, index, block_offset,
           resp_valid, resp_id, resp_hit, busy, timeout_err, access_count, miss_count
  );
endinterface

// File: rtl/l1_access_arbiter.sv
// Two-requester round-robin arbiter that issues one L1 lookup at a time.
// Define L1_ARB_STATS_EN to implement the saturating access/miss counters.
//
// state | meaning
// IDLE  | waiting for a request; grant is combinational
// ISSUE | address latched, find_start pulsed
// WAIT  | waiting for updated, or timing out
// RESP  | resp_valid pulse, back to IDLE
module l1_access_arbiter #(
  parameter int          BLOCK_SIZE_BYTE = 16,
  parameter int          CACHE_SIZE_BYTE = 32768,
  parameter int          WAY             = 4,
  parameter int          TIMEOUT_CYCLES  = 64,
  parameter logic [19:0] COUNT_PRESET    = 20'd0
) (
  input logic                clk,
  input logic                reset,
  l1_access_arbiter_if.slave bus
);
  localparam int OFF_W = $clog2(BLOCK_SIZE_BYTE);
  localparam int SET_W = $clog2(CACHE_SIZE_BYTE / (BLOCK_SIZE_BYTE * WAY));
  localparam int TAG_W = 32 - SET_W - OFF_W;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state_q, state_d;
  logic             rr_q;
  logic             id_q;
  logic             hit_q;
  logic             tmo_q;
  logic [31:0]      addr_q;
  logic [CNT_W-1:0] wait_cnt_q;
  logic             grant0, grant1, handshake;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE && !reset) begin
      if (bus.req0_valid && (!bus.req1_valid || !rr_q)) grant0 = 1'b1;
      else if (bus.req1_valid)                          grant1 = 1'b1;
    end
  end

  assign handshake = grant0 | grant1;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (handshake) state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT:  if (bus.updated || wait_cnt_q == '0) state_d = RESP;
      RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_q       <= 1'b0;
      id_q       <= 1'b0;
      hit_q      <= 1'b0;
      tmo_q      <= 1'b0;
      addr_q     <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (handshake) begin
        rr_q   <= ~grant1;
        id_q   <= grant1;
        addr_q <= grant1 ? bus.req1_addr : bus.req0_addr;
      end
      if (state_q == ISSUE) wait_cnt_q <= CNT_W'(TIMEOUT_CYCLES - 1);
      // updated wins over the timeout when both land on the last WAIT cycle
      if (state_q == WAIT) begin
        if (bus.updated) begin
          hit_q <= bus.found_in_cache;
        end else if (wait_cnt_q == '0) begin
          hit_q <= 1'b0;
          tmo_q <= 1'b1;
        end else begin
          wait_cnt_q <= wait_cnt_q - CNT_W'(1);
        end
      end
    end
  end

  assign bus.req0_ready   = grant0;
  assign bus.req1_ready   = grant1;
  assign bus.find_start   = (state_q == ISSUE);
  assign bus.resp_valid   = (state_q == RESP);
  assign bus.resp_id      = id_q;
  assign bus.resp_hit     = hit_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.timeout_err  = tmo_q;
  assign bus.tag          = addr_q[31:SET_W+OFF_W];
  assign bus.index        = addr_q[SET_W+OFF_W-1:OFF_W];
  assign bus.block_offset = addr_q[OFF_W-1:0];

`ifdef L1_ARB_STATS_EN
  logic [19:0] acc_q, miss_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q  <= COUNT_PRESET;
      miss_q <= COUNT_PRESET;
    end else if (state_q == RESP) begin
      if (acc_q != 20'hFFFFF)            acc_q  <= acc_q + 20'd1;
      if (!hit_q && miss_q != 20'hFFFFF) miss_q <= miss_q + 20'd1;
    end
  end

  assign bus.access_count = acc_q;
  assign bus.miss_count   = miss_q;
`else
  logic unused_preset;
  assign unused_preset    = ^COUNT_PRESET;
  assign bus.access_count = 20'd0;
  assign bus.miss_count   = 20'd0;
`endif
endmodule

// File: tb/tb_l1_access_arbiter.sv
// Bench for l1_access_arbiter: directed scenarios plus random transactions
// checked against a transaction-level model of arbitration, address split and statistics.
module tb_l1_access_arbiter;
  localparam int TO    = 64;
  localparam int OFF_W = 4;
  localparam int SET_W = 9;
`ifdef L1_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  bit   m_rr;
  bit   m_tmo;
  int   m_acc;
  int   m_miss;

  l1_access_arbiter_if bus ();
  l1_access_arbiter_if bus_s ();

  l1_access_arbiter dut (.clk(clk), .reset(reset), .bus(bus.slave));
  l1_access_arbiter #(.COUNT_PRESET(20'hFFFFD)) dut_sat (.clk(clk), .reset(reset), .bus(bus_s.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int n);
    if (!STATS) return 32'd0;
    return (n > 32'hFFFFF) ? 32'hFFFFF : 32'(n);
  endfunction

  task automatic model_reset();
    m_rr = 1'b0; m_tmo = 1'b0; m_acc = 0; m_miss = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  // Entered just after a rising edge with the arbiter idle; leaves it the same way.
  task automatic do_access(input bit v0, input bit v1, input logic [31:0] a0, input logic [31:0] a1,
                           input bit tmo, input int dly, input bit found, input bit spurious);
    bit          exp_id, exp_hit, early;
    logic [31:0] a;
    int          c;
    bus.req0_valid = v0; bus.req1_valid = v1;
    bus.req0_addr  = a0; bus.req1_addr  = a1;
    @(negedge clk);
    exp_id = (v0 && v1) ? m_rr : v1;
    check_eq("ready0", bus.req0_ready, !exp_id);
    check_eq("ready1", bus.req1_ready, exp_id);
    @(posedge clk); #1;
    m_rr = !exp_id;
    a = exp_id ? a1 : a0;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    check_eq("find_start", bus.find_start, 1);
    check_eq("tag", bus.tag, a >> (SET_W + OFF_W));
    check_eq("index", bus.index, (a >> OFF_W) & ((32'd1 << SET_W) - 1));
    check_eq("block_offset", bus.block_offset, a & ((32'd1 << OFF_W) - 1));
    if (spurious) begin
      bus.updated = 1'b1; bus.found_in_cache = 1'b1;
    end
    @(posedge clk); #1;
    bus.updated = 1'b0;
    check_eq("find_start_one_cycle", bus.find_start, 0);
    c = 0; early = 1'b0;
    forever begin
      if (!tmo && c == dly) begin
        bus.updated = 1'b1; bus.found_in_cache = found;
      end
      @(posedge clk); #1;
      bus.updated = 1'b0;
      if ((!tmo && c == dly) || (tmo && c == TO - 1) || c > TO + 4) break;
      early |= bus.resp_valid;
      c++;
    end
    check_eq("no_early_resp", early, 0);
    exp_hit = tmo ? 1'b0 : found;
    if (tmo) m_tmo = 1'b1;
    check_eq("resp_valid", bus.resp_valid, 1);
    check_eq("resp_id", bus.resp_id, exp_id);
    check_eq("resp_hit", bus.resp_hit, exp_hit);
    m_acc++;
    if (!exp_hit) m_miss++;
    @(posedge clk); #1;
    check_eq("resp_one_cycle", bus.resp_valid, 0);
    check_eq("busy_idle", bus.busy, 0);
    check_eq("timeout_err", bus.timeout_err, m_tmo);
    check_eq("access_count", bus.access_count, exp_cnt(m_acc));
    check_eq("miss_count", bus.miss_count, exp_cnt(m_miss));
  endtask

  initial begin
    bit exp_id, seen, early;
    reset = 1'b1;
    bus.req0_valid = 0; bus.req1_valid = 0; bus.req0_addr = 0; bus.req1_addr = 0;
    bus.updated = 0; bus.found_in_cache = 0;
    bus_s.req0_valid = 1; bus_s.req1_valid = 0; bus_s.req0_addr = 32'h40; bus_s.req1_addr = 0;
    bus_s.updated = 1; bus_s.found_in_cache = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();

    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_find_start", bus.find_start, 0);
    check_eq("rst_resp_valid", bus.resp_valid, 0);
    check_eq("rst_tag", bus.tag, 0);
    check_eq("rst_index", bus.index, 0);
    check_eq("rst_timeout_err", bus.timeout_err, 0);
    check_eq("rst_access_count", bus.access_count, 0);

    // both requesters held valid from reset, L1 answers hit immediately
    bus.updated = 1; bus.found_in_cache = 1;
    bus.req0_valid = 1; bus.req1_valid = 1;
    bus.req0_addr = 32'hA000_0010; bus.req1_addr = 32'hB000_0020;
    for (int g = 0; g < 4; g++) begin
      seen = 1'b0;
      for (int w = 0; w < 20; w++) begin
        @(negedge clk);
        if (bus.req0_ready || bus.req1_ready) begin seen = 1'b1; break; end
        if (bus.busy) check_eq("no_grant_while_busy", bus.req0_ready | bus.req1_ready, 0);
      end
      check_eq("grant_seen", seen, 1);
      exp_id = m_rr;
      check_eq("rr_ready0", bus.req0_ready, !exp_id);
      check_eq("rr_ready1", bus.req1_ready, exp_id);
      check_eq("rr_order", exp_id, g % 2);
      m_rr = !exp_id; m_acc++;
      @(posedge clk); #1;
    end
    bus.req0_valid = 0; bus.req1_valid = 0;
    for (int w = 0; w < 20; w++) begin
      @(negedge clk);
      if (!bus.busy) break;
    end
    check_eq("rr_drain_idle", bus.busy, 0);
    check_eq("rr_access_count", bus.access_count, exp_cnt(m_acc));
    check_eq("rr_miss_count", bus.miss_count, exp_cnt(m_miss));
    bus.updated = 0; bus.found_in_cache = 0;
    @(posedge clk); #1;

    // single req0 at 0x1234, updated two cycles after find_start with a hit
    do_reset();
    do_access(1, 0, 32'h0000_1234, 32'h0, 0, 1, 1, 0);
    check_eq("d1_access_count", bus.access_count, STATS ? 1 : 0);
    check_eq("d1_miss_count", bus.miss_count, 0);

    // L1 never answers: timeout, then sticky flag survives a normal access
    do_access(1, 0, $urandom, 32'h0, 1, 0, 0, 0);
    do_access(0, 1, 32'h0, $urandom, 0, 3, 1, 1);

    for (int t = 0; t < 40; t++) begin
      int unsigned vp;
      vp = $urandom_range(1, 3);
      do_access(vp[0], vp[1], $urandom, $urandom, ($urandom_range(0, 9) == 0),
                $urandom_range(0, 20), $urandom_range(0, 1), $urandom_range(0, 1));
    end

    // reset in the middle of WAIT drops the request
    bus.req0_valid = 1; bus.req0_addr = $urandom;
    @(posedge clk); #1;
    bus.req0_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("pre_reset_busy", bus.busy, 1);
    reset = 1'b1; bus.req0_valid = 1;
    @(negedge clk);
    check_eq("ready_in_reset", bus.req0_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0; bus.req0_valid = 0;
    model_reset();
    check_eq("midwait_busy", bus.busy, 0);
    check_eq("midwait_resp_valid", bus.resp_valid, 0);
    check_eq("midwait_timeout_err", bus.timeout_err, 0);
    check_eq("midwait_tag", bus.tag, 0);
    check_eq("midwait_offset", bus.block_offset, 0);
    check_eq("midwait_resp_id", bus.resp_id, 0);
    check_eq("midwait_miss_count", bus.miss_count, 0);
    early = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      early |= bus.resp_valid;
    end
    check_eq("dropped_no_resp", early, 0);
    do_access(1, 1, $urandom, $urandom, 0, 2, 0, 0);

    repeat (40) @(posedge clk);
    #1;
    check_eq("sat_miss_count", bus_s.miss_count, STATS ? 32'hFFFFF : 0);
    check_eq("sat_access_count", bus_s.access_count, STATS ? 32'hFFFFF : 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
